// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, arbiter FSM encoding and default ALU latency.
package alu_pkg;

  localparam logic [2:0] OP_ADD      = 3'd0;
  localparam logic [2:0] OP_SUB      = 3'd1;
  localparam logic [2:0] OP_AND      = 3'd2;
  localparam logic [2:0] OP_OR       = 3'd3;
  localparam logic [2:0] OP_NOT      = 3'd4;
  localparam logic [2:0] OP_SLL      = 3'd5;
  localparam logic [2:0] OP_SRL      = 3'd6;
  localparam logic [2:0] OP_OUTPUT_A = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int ALU_LAT_DEF = 1;

  // flag = {carry, overflow, negative, zero}
  typedef struct packed {
    logic [3:0] flag;
    logic       carry;
    logic [7:0] result;
  } alu_out_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between ALU clients and the arbiter.
interface alu_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][2:0]  req_op;
  logic [NREQ-1:0][7:0]  req_a;
  logic [NREQ-1:0][7:0]  req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [7:0]            rsp_result;
  logic [3:0]            rsp_flag;
  logic                  rsp_carry;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flag, rsp_carry
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flag, rsp_carry
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = IDW'(j);
        gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/synth_wrapper.sv
// Registered 8-bit ALU; ALU_LAT register stages between operands and outputs.
module synth_wrapper
  import alu_pkg::*;
#(
  parameter int ALU_LAT = ALU_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic [3:0] alu_flag,
  output logic       carry
);
  alu_out_t   w, q;
  logic [7:0] r;
  logic       c, v;

  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        {c, r} = {1'b0, a} + {1'b0, b};
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        {c, r} = {1'b0, a} - {1'b0, b};
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOT:  r = ~a;
      OP_SLL:  r = a << b[2:0];
      OP_SRL:  r = a >> b[2:0];
      default: r = a;
    endcase
    w.result = r;
    w.carry  = c;
    w.flag   = {c, v, r[7], (r == 8'd0)};
  end

  generate
    if (ALU_LAT == 0) begin : g_comb
      assign q = w;
    end else begin : g_pipe
      alu_out_t pipe [ALU_LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < ALU_LAT; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= w;
          for (int i = 1; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign q = pipe[ALU_LAT-1];
    end
  endgenerate

  assign result   = q.result;
  assign alu_flag = q.flag;
  assign carry    = q.carry;
endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NREQ requesters: grant, issue, wait out latency, respond.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ALU_LAT = ALU_LAT_DEF,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic [2:0]        alu_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_result,
  input  logic [3:0]        alu_flag,
  input  logic              alu_carry,
  output logic              busy,
  output logic [15:0]       op_count
);
  logic [1:0]      state;
  logic [IDW-1:0]  ptr, id_q, gidx, ptr_nxt;
  logic [1:0]      cnt;
  logic [NREQ-1:0] gnt;
  logic            gany;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign ptr_nxt       = (int'(gidx) == NREQ - 1) ? '0 : gidx + IDW'(1);
  assign bus.req_ready = (state == S_IDLE && !rst) ? gnt : '0;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      ptr            <= '0;
      cnt            <= '0;
      id_q           <= '0;
      alu_op         <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= '0;
      bus.rsp_result <= '0;
      bus.rsp_flag   <= '0;
      bus.rsp_carry  <= 1'b0;
      op_count       <= '0;
    end else begin
      case (state)
        S_IDLE: if (gany) begin
          alu_op <= bus.req_op[gidx];
          alu_a  <= bus.req_a[gidx];
          alu_b  <= bus.req_b[gidx];
          id_q   <= gidx;
          cnt    <= 2'(ALU_LAT);
          ptr    <= ptr_nxt;
          state  <= S_WAIT;
        end
        S_WAIT: if (cnt != 2'd0) begin
          cnt <= cnt - 2'd1;
        end else begin
          // ALU outputs reflect the issued operands once the count drains
          bus.rsp_result <= alu_result;
          bus.rsp_flag   <= alu_flag;
          bus.rsp_carry  <= alu_carry;
          bus.rsp_id     <= id_q;
          bus.rsp_valid  <= 1'b1;
          state          <= S_RESP;
        end
        S_RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          op_count      <= op_count + 16'd1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random checks of alu_arbiter driving synth_wrapper with ALU_LAT=1.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [3:0]  alu_flag;
  logic        alu_carry, busy;
  logic [15:0] op_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_arbiter #(.NREQ(NREQ), .ALU_LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flag(alu_flag), .alu_carry(alu_carry),
    .busy(busy), .op_count(op_count)
  );

  synth_wrapper #(.ALU_LAT(LAT)) alu (
    .clk(clk), .rst_n(~rst), .op(alu_op), .a(alu_a), .b(alu_b),
    .result(alu_result), .alu_flag(alu_flag), .carry(alu_carry)
  );

  // {flag, carry, result} with flag = {carry, overflow, negative, zero}
  function automatic logic [12:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int x, y, sa, sb, s;
    logic [7:0] r;
    logic c, v;
    x = a; y = b;
    sa = (x > 127) ? x - 256 : x;
    sb = (y > 127) ? y - 256 : y;
    c = 1'b0; v = 1'b0; r = 8'd0;
    case (op)
      3'd0: begin s = x + y; r = 8'(s); c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin s = x - y; r = 8'(s); c = (x < y);   v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ~a;
      3'd5: r = 8'(x * (1 << (y % 8)));
      3'd6: r = 8'(x / (1 << (y % 8)));
      default: r = a;
    endcase
    return {c, v, r[7], (r == 8'd0), c, r};
  endfunction

  // Issue one request and wait for its response; rsp_ready is the caller's job.
  task automatic do_op(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic ok, output int lat, output logic [IDW-1:0] rid,
                       output logic [7:0] r, output logic [3:0] f, output logic c);
    ok = 1'b0; lat = 0; rid = '0; r = '0; f = '0; c = 1'b0;
    bus.req_op[id] = op; bus.req_a[id] = a; bus.req_b[id] = b; bus.req_valid[id] = 1'b1;
    #1;
    for (int t = 0; t < 20 && !bus.req_ready[id]; t++) begin @(negedge clk); #1; end
    if (!bus.req_ready[id]) begin bus.req_valid[id] = 1'b0; return; end
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
    while (!bus.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!bus.rsp_valid) return;
    ok = 1'b1; rid = bus.rsp_id; r = bus.rsp_result; f = bus.rsp_flag; c = bus.rsp_carry;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    checks++; if ({bus.rsp_id, bus.rsp_result, bus.rsp_flag, bus.rsp_carry} !== 15'd0) begin errors++;
      $display("FAIL reset_rsp_fields got %h want 0", {bus.rsp_id, bus.rsp_result, bus.rsp_flag, bus.rsp_carry}); end
    checks++; if ({alu_op, alu_a, alu_b} !== 19'd0) begin errors++; $display("FAIL reset_alu got %h want 0", {alu_op, alu_a, alu_b}); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got %0d want 0", op_count); end
    bus.req_valid = '0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    logic ok, c; int lat; logic [IDW-1:0] rid; logic [7:0] r; logic [3:0] f;
    bus.rsp_ready = 1'b1;
    do_op(0, OP_ADD, 8'h7F, 8'h01, ok, lat, rid, r, f, c);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL add_timeout got %b want 1", ok); end
    checks++; if (lat != 2) begin errors++; $display("FAIL add_latency got %0d want 2", lat); end
    checks++; if (rid !== 2'd0) begin errors++; $display("FAIL add_id got %0d want 0", rid); end
    checks++; if (r !== 8'h80) begin errors++; $display("FAIL add_result got %h want 80", r); end
    checks++; if (f !== 4'b0110 || c !== 1'b0) begin errors++; $display("FAIL add_flags got %b/%b want 0110/0", f, c); end
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL add_op_count got %0d want 1", op_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_after got %b want 0", busy); end
  endtask

  task automatic test_ops_req2();
    logic [2:0] ops [4] = '{OP_SUB, OP_SLL, OP_SRL, OP_OUTPUT_A};
    logic [7:0] av  [4] = '{8'h10, 8'h81, 8'h81, 8'h5A};
    logic [7:0] bv  [4] = '{8'h20, 8'h09, 8'h0F, 8'h00};
    logic [7:0] er  [4] = '{8'hF0, 8'h02, 8'h01, 8'h5A};
    logic [3:0] ef  [4] = '{4'b1010, 4'b0000, 4'b0000, 4'b0000};
    logic       ec  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic ok, c; int lat; logic [IDW-1:0] rid; logic [7:0] r; logic [3:0] f;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_op(2, ops[k], av[k], bv[k], ok, lat, rid, r, f, c);
      checks++; if (ok !== 1'b1 || rid !== 2'd2) begin errors++; $display("FAIL op%0d_id got ok=%b id=%0d want 1/2", k, ok, rid); end
      checks++; if (r !== er[k]) begin errors++; $display("FAIL op%0d_result got %h want %h", k, r, er[k]); end
      checks++; if (f !== ef[k] || c !== ec[k]) begin errors++; $display("FAIL op%0d_flags got %b/%b want %b/%b", k, f, c, ef[k], ec[k]); end
    end
    checks++; if (op_count !== 16'd5) begin errors++; $display("FAIL ops_op_count got %0d want 5", op_count); end
  endtask

  task automatic test_round_robin();
    int gid [6]; int rid [6]; int rres [6]; int rcyc [6];
    int ng = 0, nr = 0;
    pulse_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op[i] = OP_OUTPUT_A; bus.req_a[i] = 8'(8'h10 + i); bus.req_b[i] = 8'h00;
    end
    bus.req_valid = '1;
    for (int t = 0; t < 80 && nr < 6; t++) begin
      #1;
      if (|bus.req_ready && ng < 6) begin
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gid[ng] = i;
        ng++;
      end
      if (bus.rsp_valid) begin
        rid[nr] = int'(bus.rsp_id); rres[nr] = int'(bus.rsp_result); rcyc[nr] = t; nr++;
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    checks++; if (nr != 6 || ng != 6) begin errors++; $display("FAIL rr_timeout got %0d/%0d want 6/6", ng, nr); end
    for (int k = 0; k < nr && k < ng; k++) begin
      checks++; if (gid[k] != k % 4) begin errors++; $display("FAIL rr_grant%0d got %0d want %0d", k, gid[k], k % 4); end
      checks++; if (rid[k] != k % 4) begin errors++; $display("FAIL rr_rsp_id%0d got %0d want %0d", k, rid[k], k % 4); end
      checks++; if (rres[k] != 16 + k % 4) begin errors++; $display("FAIL rr_result%0d got %h want %h", k, rres[k], 16 + k % 4); end
      if (k > 0) begin
        checks++; if (rcyc[k] - rcyc[k-1] != 4) begin errors++; $display("FAIL rr_spacing%0d got %0d want 4", k, rcyc[k] - rcyc[k-1]); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [15:0] oc;
    int t;
    bus.rsp_ready = 1'b0;
    oc = op_count;
    bus.req_op[1] = OP_ADD; bus.req_a[1] = 8'h03; bus.req_b[1] = 8'h04; bus.req_valid[1] = 1'b1;
    #1;
    for (t = 0; t < 20 && !bus.req_ready[1]; t++) begin @(negedge clk); #1; end
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    for (t = 0; t < 20 && !bus.rsp_valid; t++) @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout got %b want 1", bus.rsp_valid); end
    bus.req_op[3] = OP_OUTPUT_A; bus.req_a[3] = 8'h3C; bus.req_b[3] = 8'h00; bus.req_valid[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flag, bus.rsp_carry} !== {1'b1, 2'd1, 8'h07, 4'b0000, 1'b0}) begin
        errors++; $display("FAIL bp_hold%0d got %h want %h", k,
          {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_flag, bus.rsp_carry}, {1'b1, 2'd1, 8'h07, 4'b0000, 1'b0}); end
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_req_ready%0d got %b want 0000", k, bus.req_ready); end
      if (k == 3) bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || op_count !== oc + 16'd1) begin errors++;
      $display("FAIL bp_handshake got v=%b cnt=%0d want 0/%0d", bus.rsp_valid, op_count, oc + 16'd1); end
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_accept got %b want 1000", bus.req_ready); end
    @(negedge clk);
    bus.req_valid[3] = 1'b0;
    for (t = 0; t < 20 && !bus.rsp_valid; t++) @(negedge clk);
    checks++; if (bus.rsp_id !== 2'd3 || bus.rsp_result !== 8'h3C) begin errors++;
      $display("FAIL bp_second got id=%0d res=%h want 3/3c", bus.rsp_id, bus.rsp_result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    int t;
    bus.rsp_ready = 1'b1;
    bus.req_op[2] = OP_ADD; bus.req_a[2] = 8'h01; bus.req_b[2] = 8'h01; bus.req_valid[2] = 1'b1;
    #1;
    for (t = 0; t < 20 && !bus.req_ready[2]; t++) begin @(negedge clk); #1; end
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_state got busy=%b v=%b want 0/0", busy, bus.rsp_valid); end
    checks++; if ({alu_op, alu_a, alu_b} !== 19'd0 || op_count !== 16'd0) begin errors++;
      $display("FAIL mid_regs got alu=%h cnt=%0d want 0/0", {alu_op, alu_a, alu_b}, op_count); end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); if (bus.rsp_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0 || op_count !== 16'd0) begin errors++; $display("FAIL mid_no_rsp got seen=%b cnt=%0d want 0/0", seen, op_count); end
    bus.req_op[1] = OP_OR; bus.req_a[1] = 8'hF0; bus.req_b[1] = 8'h0F;
    bus.req_valid[1] = 1'b1; bus.req_valid[3] = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ptr0 got %b want 0010", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    for (t = 0; t < 20 && !bus.rsp_valid; t++) @(negedge clk);
    checks++; if (bus.rsp_id !== 2'd1 || bus.rsp_result !== 8'hFF) begin errors++;
      $display("FAIL mid_after got id=%0d res=%h want 1/ff", bus.rsp_id, bus.rsp_result); end
    @(negedge clk);
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL mid_op_count got %0d want 1", op_count); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] acc_last = '0;
    logic have_exp = 1'b0;
    logic [2:0] eop; logic [7:0] ea, eb; int eid = 0;
    logic [12:0] exp_v;
    int issued = 0, hs = 0, cyc = 0, g;
    pulse_reset();
    bus.req_valid = '0;
    while ((issued < 1000 || have_exp) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bus.req_valid = bus.req_valid & ~acc_last;
      acc_last = '0;
      if (issued < 1000) begin
        for (int i = 0; i < NREQ; i++)
          if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) begin
            bus.req_op[i] = 3'($urandom_range(0, 7)); bus.req_a[i] = 8'($urandom); bus.req_b[i] = 8'($urandom);
            bus.req_valid[i] = 1'b1;
          end
      end else bus.req_valid = '0;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if ($countones(bus.req_ready) > 1) begin errors++; $display("FAIL rnd_onehot got %b want <=1 bit", bus.req_ready); end
      if (|(bus.req_valid & bus.req_ready)) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
        eid = g; eop = bus.req_op[g]; ea = bus.req_a[g]; eb = bus.req_b[g];
        have_exp = 1'b1; issued++;
        acc_last = bus.req_ready;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        exp_v = ref_alu(eop, ea, eb);
        checks++; if (!have_exp || int'(bus.rsp_id) != eid ||
                      {bus.rsp_flag, bus.rsp_carry, bus.rsp_result} !== exp_v) begin errors++;
          $display("FAIL rnd_rsp%0d got id=%0d %h want id=%0d %h", hs, bus.rsp_id,
                   {bus.rsp_flag, bus.rsp_carry, bus.rsp_result}, eid, exp_v); end
        have_exp = 1'b0; hs++;
      end
    end
    checks++; if (issued != 1000 || have_exp) begin errors++; $display("FAIL rnd_timeout got %0d issued want 1000", issued); end
    @(negedge clk);
    checks++; if (op_count !== 16'(hs)) begin errors++; $display("FAIL rnd_op_count got %0d want %0d", op_count, 16'(hs)); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_ops_req2();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
